// File: rtl/pu_io_initiator.sv
// pu_io_initiator: single-outstanding LSU-to-IO request initiator with ack timeout
module pu_io_initiator #(
    parameter int WIDTH_NBITS   = 32,
    parameter int ADDR_NBITS    = 32,
    parameter int TID_NBITS     = 8,
    parameter int TIMEOUT_NBITS = 10,
    localparam int CMD_NBITS    = 7 + ADDR_NBITS + TID_NBITS + WIDTH_NBITS
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic                   lsu_wr,
    input  logic                   lsu_atomic,
    input  logic [4:0]             lsu_funct5,
    input  logic [ADDR_NBITS-1:0]  lsu_addr,
    input  logic [TID_NBITS-1:0]   lsu_tid,
    input  logic [WIDTH_NBITS-1:0] lsu_wdata,
    output logic                   lsu_rvalid,
    output logic [WIDTH_NBITS-1:0] lsu_rdata,
    output logic                   lsu_wdone,
    output logic                   lsu_err,
    output logic                   io_req,
    output logic [CMD_NBITS-1:0]   io_cmd,
    input  logic                   io_ack,
    input  logic [WIDTH_NBITS-1:0] io_ack_data,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_spurious
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // io_cmd field order, MSB first: {wr, atomic, funct5, addr, tid, wdata}
    typedef struct packed {
        logic                   wr;
        logic                   atomic;
        logic [4:0]             funct5;
        logic [ADDR_NBITS-1:0]  addr;
        logic [TID_NBITS-1:0]   tid;
        logic [WIDTH_NBITS-1:0] wdata;
    } io_type;

    state_t                   state, next;
    io_type                   cmd;
    logic [TIMEOUT_NBITS-1:0] cnt;
    logic [WIDTH_NBITS-1:0]   data_q;
    logic                     rd, timeout, accept;

    assign io_cmd = cmd;
    assign rd     = cmd.atomic || !cmd.wr;
    assign accept = lsu_valid && lsu_ready;

    // next-state and per-state output decode; ack beats timeout in the same cycle
    always_comb begin
        next       = state;
        lsu_ready  = 1'b0;
        io_req     = 1'b0;
        busy       = 1'b0;
        lsu_rvalid = 1'b0;
        lsu_wdone  = 1'b0;
        lsu_err    = 1'b0;
        lsu_rdata  = '0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                lsu_ready = 1'b1;
                next      = lsu_valid ? REQ : IDLE;
            end
            REQ: begin
                io_req = 1'b1;
                busy   = 1'b1;
                next   = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (io_ack) next = RESP;
                else if (&cnt) begin
                    timeout    = 1'b1;
                    lsu_err    = 1'b1;
                    lsu_rvalid = rd;
                    next       = IDLE;
                end
            end
            default: begin
                lsu_ready  = 1'b1;
                lsu_rvalid = rd;
                lsu_wdone  = !rd;
                lsu_rdata  = rd ? data_q : '0;
                next       = lsu_valid ? REQ : IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next;
    end

    // command register only changes on a handshake, so io_cmd is stable while outstanding
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       cmd <= '0;
        else if (accept) cmd <= '{lsu_wr, lsu_atomic, lsu_funct5, lsu_addr, lsu_tid, lsu_wdata};
    end

    // wait counter cleared while issuing, saturating while waiting; ack data captured in WAIT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt    <= '0;
            data_q <= '0;
        end else begin
            if (state == REQ) cnt <= '0;
            else if (state == WAIT && !io_ack) cnt <= &cnt ? cnt : cnt + 1'b1;
            if (state == WAIT && io_ack) data_q <= io_ack_data;
        end
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (timeout) err_timeout <= 1'b1;
            if (io_ack && state != WAIT) err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pu_io_initiator.sv
// tb_pu_io_initiator: directed self-checking bench for pu_io_initiator
module tb_pu_io_initiator;
    localparam int W  = 32;
    localparam int A  = 32;
    localparam int T  = 8;
    localparam int CW = 7 + A + T + W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          lsu_valid = 1'b0, lsu_ready, lsu_wr = 1'b0, lsu_atomic = 1'b0;
    logic [4:0]    lsu_funct5 = '0;
    logic [A-1:0]  lsu_addr = '0;
    logic [T-1:0]  lsu_tid = '0;
    logic [W-1:0]  lsu_wdata = '0, lsu_rdata, io_ack_data = '0;
    logic          lsu_rvalid, lsu_wdone, lsu_err, io_req, io_ack = 1'b0;
    logic [CW-1:0] io_cmd;
    logic          busy, err_timeout, err_spurious;
    int            n_cmp = 0, n_err = 0, n_req = 0;
    logic [CW-1:0] exp_cmd;

    pu_io_initiator #(.WIDTH_NBITS(W), .ADDR_NBITS(A), .TID_NBITS(T), .TIMEOUT_NBITS(4)) dut (
        .clk(clk), .rstn(rstn), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wr(lsu_wr),
        .lsu_atomic(lsu_atomic), .lsu_funct5(lsu_funct5), .lsu_addr(lsu_addr), .lsu_tid(lsu_tid),
        .lsu_wdata(lsu_wdata), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_wdone(lsu_wdone),
        .lsu_err(lsu_err), .io_req(io_req), .io_cmd(io_cmd), .io_ack(io_ack), .io_ack_data(io_ack_data),
        .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (io_req) n_req++;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input logic wr, input logic at, input logic [4:0] f5,
                                         input logic [A-1:0] a, input logic [T-1:0] t, input logic [W-1:0] d);
        return {wr, at, f5, a, t, d};
    endfunction

    task automatic drive(input logic wr, input logic at, input logic [4:0] f5,
                         input logic [A-1:0] a, input logic [T-1:0] t, input logic [W-1:0] d);
        lsu_valid = 1'b1; lsu_wr = wr; lsu_atomic = at; lsu_funct5 = f5;
        lsu_addr = a; lsu_tid = t; lsu_wdata = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        // reset values
        tick(); #1;
        chk("rst_ready", lsu_ready, 1);
        chk("rst_req", io_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd", io_cmd, 0);
        chk("rst_rdata", lsu_rdata, 0);
        chk("rst_flags", {err_timeout, err_spurious, lsu_rvalid, lsu_wdone, lsu_err}, 0);
        tick(); rstn = 1'b1;

        // load addr 0x10 tid 3, ack 4 cycles after io_req
        tick(); drive(0, 0, 5'd0, 32'h10, 8'd3, 32'h0); #1;
        chk("ld_ready", lsu_ready, 1);
        exp_cmd = mk(0, 0, 5'd0, 32'h10, 8'd3, 32'h0);
        tick(); lsu_valid = 1'b0; #1;
        chk("ld_req", io_req, 1);
        chk("ld_busy", busy, 1);
        chk("ld_notready", lsu_ready, 0);
        chk("ld_cmd", io_cmd, exp_cmd);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("ld_wait_req", io_req, 0);
            chk("ld_wait_cmd", io_cmd, exp_cmd);
            chk("ld_wait_rvalid", lsu_rvalid, 0);
        end
        tick(); io_ack = 1'b1; io_ack_data = 32'hA5A5_0001; #1;
        chk("ld_ack_busy", busy, 1);
        chk("ld_ack_cmd", io_cmd, exp_cmd);
        tick(); io_ack = 1'b0; #1;
        chk("ld_rvalid", lsu_rvalid, 1);
        chk("ld_rdata", lsu_rdata, 32'hA5A5_0001);
        chk("ld_wdone", lsu_wdone, 0);
        chk("ld_resp_busy", busy, 0);
        tick(); #1;
        chk("ld_rvalid_pulse", lsu_rvalid, 0);
        chk("ld_nreq", n_req, 1);

        // store then back-to-back load with lsu_valid held
        drive(1, 0, 5'd0, 32'h20, 8'd5, 32'h1234);
        tick(); drive(0, 0, 5'd0, 32'h24, 8'd6, 32'h0); #1;
        chk("st_req", io_req, 1);
        chk("st_cmd", io_cmd, mk(1, 0, 5'd0, 32'h20, 8'd5, 32'h1234));
        tick(); io_ack = 1'b1; io_ack_data = 32'hDEAD; #1;
        chk("st_wait_cmd", io_cmd, mk(1, 0, 5'd0, 32'h20, 8'd5, 32'h1234));
        tick(); io_ack = 1'b0; #1;
        chk("st_wdone", lsu_wdone, 1);
        chk("st_rvalid", lsu_rvalid, 0);
        chk("st_rdata", lsu_rdata, 0);
        chk("st_ready", lsu_ready, 1);
        tick(); lsu_valid = 1'b0; #1;
        chk("b2b_req", io_req, 1);
        chk("b2b_cmd", io_cmd, mk(0, 0, 5'd0, 32'h24, 8'd6, 32'h0));
        chk("b2b_wdone", lsu_wdone, 0);
        tick(); io_ack = 1'b1; io_ack_data = 32'h55; #1;
        tick(); io_ack = 1'b0; #1;
        chk("b2b_rvalid", lsu_rvalid, 1);
        chk("b2b_rdata", lsu_rdata, 32'h55);
        chk("b2b_nreq", n_req, 3);

        // atomic add
        tick(); drive(1, 1, 5'b00000, 32'h30, 8'd7, 32'h3); #1;
        chk("amo_ready", lsu_ready, 1);
        tick(); lsu_valid = 1'b0; #1;
        chk("amo_cmd", io_cmd, mk(1, 1, 5'b00000, 32'h30, 8'd7, 32'h3));
        tick(); io_ack = 1'b1; io_ack_data = 32'h7; #1;
        tick(); io_ack = 1'b0; #1;
        chk("amo_rvalid", lsu_rvalid, 1);
        chk("amo_rdata", lsu_rdata, 32'h7);
        chk("amo_wdone", lsu_wdone, 0);

        // timeout after 15 wait cycles
        tick(); drive(0, 0, 5'd0, 32'h40, 8'd1, 32'h0);
        tick(); lsu_valid = 1'b0; #1;
        chk("to_req", io_req, 1);
        for (int i = 0; i < 15; i++) begin
            tick(); #1;
            chk("to_wait_err", lsu_err, 0);
            chk("to_wait_busy", busy, 1);
        end
        tick(); #1;
        chk("to_err", lsu_err, 1);
        chk("to_rvalid", lsu_rvalid, 1);
        chk("to_rdata", lsu_rdata, 0);
        tick(); #1;
        chk("to_ready", lsu_ready, 1);
        chk("to_flag", err_timeout, 1);
        chk("to_err_pulse", lsu_err, 0);
        chk("to_busy", busy, 0);
        chk("to_spur", err_spurious, 0);

        // ack exactly on the timeout cycle wins
        drive(0, 0, 5'd0, 32'h50, 8'd2, 32'h0);
        tick(); lsu_valid = 1'b0; #1;
        chk("tw_req", io_req, 1);
        for (int i = 0; i < 15; i++) tick();
        tick(); io_ack = 1'b1; io_ack_data = 32'h99; #1;
        chk("tw_noerr", lsu_err, 0);
        chk("tw_busy", busy, 1);
        tick(); io_ack = 1'b0; #1;
        chk("tw_rvalid", lsu_rvalid, 1);
        chk("tw_rdata", lsu_rdata, 32'h99);
        chk("tw_err", lsu_err, 0);
        chk("tw_spur", err_spurious, 0);

        // spurious ack while idle
        tick(); io_ack = 1'b1; #1;
        chk("sp_pre", err_spurious, 0);
        tick(); io_ack = 1'b0; #1;
        chk("sp_flag", err_spurious, 1);
        chk("sp_rvalid", lsu_rvalid, 0);
        chk("sp_ready", lsu_ready, 1);
        chk("sp_busy", busy, 0);

        // reset during WAIT, then late ack
        tick(); drive(0, 0, 5'd0, 32'h60, 8'd4, 32'h0);
        tick(); lsu_valid = 1'b0;
        tick(); #1;
        chk("rw_busy_pre", busy, 1);
        rstn = 1'b0; #1;
        chk("rw_busy", busy, 0);
        chk("rw_ready", lsu_ready, 1);
        chk("rw_cmd", io_cmd, 0);
        chk("rw_flags", {err_timeout, err_spurious}, 0);
        tick(); rstn = 1'b1;
        tick(); io_ack = 1'b1; io_ack_data = 32'h77; #1;
        chk("rw_late_rvalid", lsu_rvalid, 0);
        chk("rw_late_busy", busy, 0);
        tick(); io_ack = 1'b0; #1;
        chk("rw_spur", err_spurious, 1);
        chk("rw_resp", {lsu_rvalid, lsu_wdone, lsu_err}, 0);
        chk("rw_ready2", lsu_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pu_io_initiator.md
PU_IO_INITIATOR -- requirements
Module: pu_io_initiator

Interface
REQ-001 Parameter WIDTH_NBITS, default 32: data width of io_cmd.wdata, io_ack_data, lsu_wdata and lsu_rdata.
REQ-002 Parameter ADDR_NBITS, default 32: width of the request address.
REQ-003 Parameter TID_NBITS, default 8: width of the topic/thread id carried with each command.
REQ-004 Parameter TIMEOUT_NBITS, default 10: width of the ack-wait counter; timeout fires at 2**TIMEOUT_NBITS-1 wait cycles.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rstn  input  1  reset, asynchronous assert, active-low.
REQ-007 lsu_valid  input  1  core request valid.
REQ-008 lsu_ready  output  1  initiator accepts the request this cycle.
REQ-009 lsu_wr, lsu_atomic  input  1 each  store / atomic read-modify-write qualifiers.
REQ-010 lsu_funct5  input  5  atomic opcode, passed through unchanged.
REQ-011 lsu_addr  input  ADDR_NBITS  word address; lsu_tid  input  TID_NBITS  topic id; lsu_wdata  input  WIDTH_NBITS  store/operand data.
REQ-012 lsu_rvalid  output  1  one-cycle pulse: load/atomic data on lsu_rdata (WIDTH_NBITS).
REQ-013 lsu_wdone  output  1  one-cycle pulse: plain store acknowledged.
REQ-014 lsu_err  output  1  one-cycle pulse: request terminated by timeout.
REQ-015 io_req  output  1  one-cycle request strobe to the shared memory responder.
REQ-016 io_cmd  output  io_type  command {wr, atomic, funct5, addr, tid, wdata}.
REQ-017 io_ack  input  1  responder completion; io_ack_data  input  WIDTH_NBITS  returned data.
REQ-018 busy  output  1  a request is held or outstanding; err_timeout, err_spurious  output  1 each  sticky status flags.

Function
REQ-019 FSM states IDLE, REQ, WAIT, RESP; at most one request outstanding at any time, because the responder holds a single-entry queue per PU.
REQ-020 lsu_ready is 1 in IDLE and RESP, 0 in REQ and WAIT; a handshake occurs when lsu_valid and lsu_ready are both 1.
REQ-021 On handshake: register lsu_wr, lsu_atomic, lsu_funct5, lsu_addr, lsu_tid and lsu_wdata into the command register; next state REQ.
REQ-022 REQ: io_req=1 for exactly one cycle; io_cmd is driven from the command register; next state WAIT; wait counter cleared to 0.
REQ-023 io_cmd is held stable from REQ through the end of WAIT; it changes only on a new handshake.
REQ-024 WAIT: the wait counter increments by 1 per cycle without ack, saturating at all-ones.
REQ-025 WAIT and io_ack=1: capture io_ack_data; next state RESP.
REQ-026 RESP, captured command read or atomic (atomic=1 or wr=0): lsu_rvalid=1 and lsu_rdata = captured data for one cycle.
REQ-027 RESP, captured command plain store (wr=1, atomic=0): lsu_wdone=1 for one cycle; lsu_rdata=0; io_ack_data is discarded.
REQ-028 RESP: if lsu_valid=1, accept the new request and go to REQ (back-to-back issue); otherwise go to IDLE.
REQ-029 Minimum issue interval is 3 cycles plus responder ack latency (REQ, >=1 WAIT, RESP).
REQ-030 WAIT timeout: counter reaches all-ones with io_ack=0 -> lsu_err=1, lsu_rvalid=1 for reads/atomics with lsu_rdata=0, err_timeout set; next state IDLE.
REQ-031 io_ack in the same cycle as the timeout: the ack wins; no error is raised.
REQ-032 io_ack received in any state other than WAIT: ignored, err_spurious set, no FSM effect.
REQ-033 busy=1 in REQ and WAIT, 0 otherwise.
REQ-034 err_timeout and err_spurious clear only on reset.

Reset
REQ-035 While rstn=0: state IDLE; io_req, lsu_rvalid, lsu_wdone, lsu_err, busy, err_timeout, err_spurious all 0; lsu_rdata=0; io_cmd=0; wait counter 0.
REQ-036 Reset asserted mid-transaction abandons the outstanding request; after release lsu_ready=1 and no response pulse is produced for the abandoned request; a late io_ack sets err_spurious.

Verification
REQ-037 Load addr=0x10 tid=3; io_ack 4 cycles after io_req with data 0xA5A5_0001 -> one io_req pulse, io_cmd stable throughout, lsu_rvalid 1 cycle with 0xA5A5_0001.
REQ-038 Store wdata=0x1234 followed immediately by a load with lsu_valid held -> io_cmd.wr=1 then wr=0, lsu_wdone then lsu_rvalid, second io_req issued directly from RESP.
REQ-039 Atomic funct5=5'b00000 (add), ack data 0x7 -> io_cmd.atomic=1, funct5 passed through unchanged, lsu_rvalid with 0x7.
REQ-040 No ack with TIMEOUT_NBITS=4 -> lsu_err pulse 15 cycles after entering WAIT, err_timeout=1, lsu_ready=1 the following cycle; io_ack exactly on cycle 15 -> normal response, no error.
REQ-041 io_ack pulsed while IDLE -> err_spurious=1, no lsu_rvalid, state unchanged.
REQ-042 rstn low during WAIT, then late io_ack -> outputs at reset values, no lsu_rvalid, err_spurious=1.
